muldiv_unit: RTL

- Iterative multi-cycle multiply/divide unit that owns the HI/LO result registers.
- Sits beside the single-cycle ALU in the execute stage and accepts the same 32-bit operand pair plus an unsigned-mode select.
- Provides MULT/DIV (signed or unsigned) and the MTHI/MTLO register writes through a start/busy/done handshake.
- Sign handling is by magnitude conversion with a final correction cycle.

---
 rtl/muldiv_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add MULT, restoring DIV,
// magnitude-based sign handling with a final correction cycle, plus MTHI/MTLO writes.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             unsig,
    input  logic             start,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  accept, is_md;

    // iteration working registers; contents are don't-care outside RUN/FIX
    logic [WIDTH-1:0]      acc_hi, acc_lo, opnd;
    logic                  op_div, neg_q, neg_r, dz_r;
    logic                  sgn_a, sgn_b;

    logic [WIDTH:0]        mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]      fix_hi, fix_lo;
    logic [2*WIDTH-1:0]    prod, prod_fix;

    function automatic logic [WIDTH-1:0] neg_if(input logic signed [WIDTH-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic signed [2*WIDTH-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    assign accept = start && (state == IDLE);
    assign is_md  = ~op[1];
    assign busy   = (state != IDLE);
    assign sgn_a  = ~unsig & a[WIDTH-1];
    assign sgn_b  = ~unsig & b[WIDTH-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_md) state_nxt = RUN;
            RUN:     if (cancel) state_nxt = IDLE;
                     else if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        prod      = {acc_hi, acc_lo};
        prod_fix  = neg2_if(prod, neg_q);
        fix_hi    = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo    = prod_fix[WIDTH-1:0];
        if (op_div) begin
            // remainder follows the dividend; b=0 leaves |a| in the remainder, so hi=a
            fix_hi = neg_if(acc_hi, neg_r);
            fix_lo = dz_r ? '1 : neg_if(acc_lo, neg_q);
        end
    end

    always_ff @(posedge clock) begin
        if (accept && is_md) begin
            op_div <= op[0];
            neg_q  <= sgn_a ^ sgn_b;
            neg_r  <= sgn_a;
            dz_r   <= (b == '0);
            acc_hi <= '0;
            acc_lo <= neg_if(a, sgn_a);
            opnd   <= neg_if(b, sgn_b);
        end else if (state == RUN) begin
            if (op_div) begin
                // quotient bit is set when the trial subtraction does not borrow
                acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == RUN && !cancel) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            else                         cnt <= '0;
            if (accept) begin
                div_by_zero <= 1'b0;
                if (op == 2'b10) begin
                    hi   <= a;
                    done <= 1'b1;
                end else if (op == 2'b11) begin
                    lo   <= a;
                    done <= 1'b1;
                end
            end
            if (state == FIX && !cancel) begin
                hi          <= fix_hi;
                lo          <= fix_lo;
                done        <= 1'b1;
                div_by_zero <= op_div & dz_r;
            end
        end
    end

endmodule
